can_interframe_tracker: RTL and testbench
=========================================

Name: can_interframe_tracker

Overview:
- Parametrised successor to the single-rate interframe detector on the CAN timing-analysis receive path.
- Votes N-of-3 or single bit samples into one bit decision per bit time.
- Tracks the end-of-frame recessive run, intermission, optional error-passive suspend-transmission and bus idle.
- Flags overload conditions and start-of-frame, for the timing-capture unit.

Parameters:
- EOF_RUN, 8: consecutive recessive bits (ACK delimiter + EOF) that end a frame.
- IFS_BITS, 3: intermission length in bits; must be at least 2.
- SUSPEND_BITS, 8: suspend-transmission length for an error-passive node.
- CNT_W, $clog2(max(EOF_RUN,SUSPEND_BITS)+1): bit-counter width; derived, do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dIn  in  1  bus level at sample point (1 = recessive)
- samplePulse  in  1  one-cycle strobe per sample point
- rateSelector  in  1  1 = three samples per bit with majority vote; 0 = one sample per bit
- errorPassive  in  1  node is error-passive; sampled at the end of intermission
- bitValid  out  1  one-cycle pulse when a voted bit is available
- bitValue  out  1  voted bit; held between pulses
- interframePeriod  out  1  bus idle, ready to transmit
- intermission  out  1  FSM in the intermission phase
- suspendPeriod  out  1  FSM in the suspend-transmission phase
- overloadReq  out  1  one-cycle pulse: dominant bit seen in an early intermission bit
- sofDetect  out  1  one-cycle pulse: dominant bit accepted as start of frame
- bitCount  out  CNT_W  current phase bit counter (debug/timing)

Behaviour:
- Reset (async, active-high):
  - Sampler goes to sample 0.
  - FSM goes to S_FRAME with bitCount = 0.
  - All outputs go to 0.
  - Reset asserted mid-bit discards partial samples.
- Sampler:
  - rateSelector is latched on the first samplePulse of a bit and ignored until that bit completes.
  - Three-sample mode: each pulse stores dIn. On the 3rd pulse, bitValue <= majority(s0,s1,s2) and bitValid pulses the next cycle.
  - One-sample mode: the 1st pulse produces bitValid the next cycle with bitValue = dIn.
  - A samplePulse coincident with bitValid counts as the first sample of the next bit.
- Latency: sample pulse in cycle t gives bitValid in t+1. FSM state, status outputs and pulses update in t+2. All outputs are registered.
- The FSM advances only on bitValid. bitCount holds otherwise.
- S_FRAME:
  - Recessive bit: bitCount++.
  - Dominant bit: bitCount <= 0.
  - When a recessive bit makes bitCount == EOF_RUN, go to S_INTERMISSION with bitCount = 0.
- S_INTERMISSION (intermission = 1):
  - Recessive bit: bitCount++.
  - Dominant bit in bits 1..IFS_BITS-1: pulse overloadReq, go to S_FRAME with bitCount = 0.
  - Dominant bit at bit IFS_BITS: pulse sofDetect, go to S_FRAME with bitCount = 0. No overload.
  - IFS_BITS recessive bits complete: go to S_SUSPEND if errorPassive, else S_IDLE. bitCount = 0.
- S_SUSPEND (suspendPeriod = 1):
  - Recessive bit: bitCount++. When bitCount reaches SUSPEND_BITS, go to S_IDLE.
  - Dominant bit: pulse sofDetect, go to S_FRAME with bitCount = 0.
- S_IDLE (interframePeriod = 1):
  - Recessive bits: bitCount holds at 0.
  - Dominant bit: pulse sofDetect, go to S_FRAME.
- A change in errorPassive outside the intermission-to-next-state transition has no effect.
- Counter arithmetic is unsigned and never wraps; every terminal compare forces a state change.

Decomposition:
- Shared package can_timing_pkg:
  - ifsState_t enum {S_FRAME, S_INTERMISSION, S_SUSPEND, S_IDLE}
  - sampleIdx_t
  - default constants CAN_EOF_RUN = 8, CAN_IFS_BITS = 3, CAN_SUSPEND_BITS = 8.
- One sub-module, can_bit_voter: the sampler, majority vote, bitValid/bitValue generation.
- The FSM and counter stay in the top level.

Test Plan:
- Single-sample mode, 11 recessive bits after reset → intermission high for bits 9–11; interframePeriod rises 2 cycles after the 11th pulse; no overloadReq or sofDetect.
- Three-sample mode with samples 1,0,1 per bit ×11 → majority gives recessive; same result as the first test. Samples 0,0,1 at bit 5 → bitCount returns to 0 and there is no intermission.
- Intermission bit 2 dominant → overloadReq pulses exactly one cycle; state is S_FRAME with bitCount = 0. Intermission bit 3 dominant → sofDetect pulses, no overloadReq.
- errorPassive = 1 at end of intermission → suspendPeriod high for 8 bits, then interframePeriod. Dominant bit at suspend bit 4 → sofDetect; interframePeriod is never set.
- Reset asserted between the 2nd and 3rd sample of a bit in S_INTERMISSION → all outputs 0 immediately. A following 3-pulse bit is voted fresh, and the FSM restarts from S_FRAME with bitCount = 0 → 1.
- rateSelector toggled after the 1st pulse of a three-sample bit → the bit still waits for 3 pulses; the next bit uses single-sample mode.

Source files
------------

// File: rtl/can_timing_pkg.sv
//------------------------------------------------------------------------------
// Module   : can_timing_pkg
// Brief    : Shared types and default constants for the CAN interframe
//            timing-analysis receive path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package can_timing_pkg;

  // Interframe tracker phases
  typedef enum logic [1:0] {
    S_FRAME        = 2'd0,
    S_INTERMISSION = 2'd1,
    S_SUSPEND      = 2'd2,
    S_IDLE         = 2'd3
  } ifsState_t;

  // Index of the next sample within a bit time (0..2)
  typedef logic [1:0] sampleIdx_t;

  localparam int CAN_EOF_RUN      = 8;
  localparam int CAN_IFS_BITS     = 3;
  localparam int CAN_SUSPEND_BITS = 8;

  // Elaboration-time helper for deriving counter widths
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/can_bit_voter.sv
//------------------------------------------------------------------------------
// Module   : can_bit_voter
// Brief    : Collects one or three bus samples per bit time and produces a
//            single voted bit with a one-cycle valid strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_bit_voter
  import can_timing_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic dIn,
  input  logic samplePulse,
  input  logic rateSelector,
  output logic bitValid,
  output logic bitValue
);

  sampleIdx_t idx_q, idx_d;
  logic       mode_q, mode_d;     // 1 = three-sample bit in progress
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       valid_q, valid_d;
  logic       value_q, value_d;
  logic       modeEff;

  // Sample collection and vote; the rate is only taken from the input on the
  // first sample of a bit so a mid-bit change cannot split a bit.
  always_comb begin
    idx_d   = idx_q;
    mode_d  = mode_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    valid_d = 1'b0;
    value_d = value_q;
    modeEff = (idx_q == 2'd0) ? rateSelector : mode_q;
    if (samplePulse) begin
      mode_d = modeEff;
      if (!modeEff) begin
        valid_d = 1'b1;
        value_d = dIn;
        idx_d   = 2'd0;
      end else begin
        case (idx_q)
          2'd0: begin
            s0_d  = dIn;
            idx_d = 2'd1;
          end
          2'd1: begin
            s1_d  = dIn;
            idx_d = 2'd2;
          end
          default: begin
            valid_d = 1'b1;
            value_d = (s0_q & s1_q) | (s0_q & dIn) | (s1_q & dIn);
            idx_d   = 2'd0;
          end
        endcase
      end
    end
  end

  // Sampler state register; reset drops any partially collected bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      mode_q  <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      valid_q <= 1'b0;
      value_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  assign bitValid = valid_q;
  assign bitValue = value_q;

endmodule

`default_nettype wire

// File: rtl/can_interframe_tracker.sv
//------------------------------------------------------------------------------
// Module   : can_interframe_tracker
// Brief    : Tracks end-of-frame, intermission, suspend-transmission and bus
//            idle from voted CAN bits; flags overload and start-of-frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module can_interframe_tracker
  import can_timing_pkg::*;
#(
  parameter int EOF_RUN      = CAN_EOF_RUN,
  parameter int IFS_BITS     = CAN_IFS_BITS,
  parameter int SUSPEND_BITS = CAN_SUSPEND_BITS,
  // Derived width; leave at its default
  parameter int CNT_W        = $clog2(maxInt(EOF_RUN, SUSPEND_BITS) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dIn,
  input  logic             samplePulse,
  input  logic             rateSelector,
  input  logic             errorPassive,
  output logic             bitValid,
  output logic             bitValue,
  output logic             interframePeriod,
  output logic             intermission,
  output logic             suspendPeriod,
  output logic             overloadReq,
  output logic             sofDetect,
  output logic [CNT_W-1:0] bitCount
);

  ifsState_t        state_q, state_d;
  logic [CNT_W-1:0] bitCount_q, bitCount_d;
  logic             overload_q, overload_d;
  logic             sof_q, sof_d;
  logic             intermission_q, suspend_q, idle_q;
  logic [CNT_W:0]   cntInc;   // one bit wider so the terminal compare cannot wrap

  can_bit_voter u_voter (
    .clk          (clk),
    .reset        (reset),
    .dIn          (dIn),
    .samplePulse  (samplePulse),
    .rateSelector (rateSelector),
    .bitValid     (bitValid),
    .bitValue     (bitValue)
  );

  // Next-state and pulse decode; the FSM only moves on a voted bit
  always_comb begin
    state_d    = state_q;
    bitCount_d = bitCount_q;
    overload_d = 1'b0;
    sof_d      = 1'b0;
    cntInc     = {1'b0, bitCount_q} + {{CNT_W{1'b0}}, 1'b1};
    if (bitValid) begin
      case (state_q)
        S_FRAME: begin
          if (!bitValue) begin
            bitCount_d = '0;
          end else if (int'(cntInc) == EOF_RUN) begin
            state_d    = S_INTERMISSION;
            bitCount_d = '0;
          end else begin
            bitCount_d = cntInc[CNT_W-1:0];
          end
        end
        S_INTERMISSION: begin
          // cntInc is the 1-based number of the intermission bit being judged
          if (!bitValue) begin
            state_d    = S_FRAME;
            bitCount_d = '0;
            if (int'(cntInc) < IFS_BITS) overload_d = 1'b1;
            else                         sof_d      = 1'b1;
          end else if (int'(cntInc) == IFS_BITS) begin
            state_d    = errorPassive ? S_SUSPEND : S_IDLE;
            bitCount_d = '0;
          end else begin
            bitCount_d = cntInc[CNT_W-1:0];
          end
        end
        S_SUSPEND: begin
          if (!bitValue) begin
            state_d    = S_FRAME;
            bitCount_d = '0;
            sof_d      = 1'b1;
          end else if (int'(cntInc) == SUSPEND_BITS) begin
            state_d    = S_IDLE;
            bitCount_d = '0;
          end else begin
            bitCount_d = cntInc[CNT_W-1:0];
          end
        end
        default: begin
          bitCount_d = '0;
          if (!bitValue) begin
            state_d = S_FRAME;
            sof_d   = 1'b1;
          end
        end
      endcase
    end
  end

  // State, counter and registered status/pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_FRAME;
      bitCount_q     <= '0;
      overload_q     <= 1'b0;
      sof_q          <= 1'b0;
      intermission_q <= 1'b0;
      suspend_q      <= 1'b0;
      idle_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitCount_q     <= bitCount_d;
      overload_q     <= overload_d;
      sof_q          <= sof_d;
      intermission_q <= (state_d == S_INTERMISSION);
      suspend_q      <= (state_d == S_SUSPEND);
      idle_q         <= (state_d == S_IDLE);
    end
  end

  assign interframePeriod = idle_q;
  assign intermission     = intermission_q;
  assign suspendPeriod    = suspend_q;
  assign overloadReq      = overload_q;
  assign sofDetect        = sof_q;
  assign bitCount         = bitCount_q;

endmodule

`default_nettype wire

// File: tb/tb_can_interframe_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_can_interframe_tracker
// Brief    : Scoreboard bench for can_interframe_tracker with directed vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_can_interframe_tracker;

  localparam logic [1:0] ST_FR = 2'd0;
  localparam logic [1:0] ST_IM = 2'd1;
  localparam logic [1:0] ST_SU = 2'd2;
  localparam logic [1:0] ST_ID = 2'd3;

  typedef struct packed {
    logic       val;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       ovl;
    logic       sof;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dIn = 1'b1;
  logic       samplePulse = 1'b0;
  logic       rateSelector = 1'b0;
  logic       errorPassive = 1'b0;
  logic       bitValid, bitValue, interframePeriod, intermission;
  logic       suspendPeriod, overloadReq, sofDetect;
  logic [3:0] bitCount;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  can_interframe_tracker dut (
    .clk              (clk),
    .reset            (reset),
    .dIn              (dIn),
    .samplePulse      (samplePulse),
    .rateSelector     (rateSelector),
    .errorPassive     (errorPassive),
    .bitValid         (bitValid),
    .bitValue         (bitValue),
    .interframePeriod (interframePeriod),
    .intermission     (intermission),
    .suspendPeriod    (suspendPeriod),
    .overloadReq      (overloadReq),
    .sofDetect        (sofDetect),
    .bitCount         (bitCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [1:0] st, input int c,
                              input logic o, input logic s);
    exp_t e;
    e.val = v;
    e.st  = st;
    e.cnt = c[3:0];
    e.ovl = o;
    e.sof = s;
    return e;
  endfunction

  // One bit time: one or three sample pulses; expectation queued on the last
  task automatic send_bit(input logic [2:0] s, input bit three, input bit rsRest,
                          input exp_t e);
    int n;
    n = three ? 3 : 1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      samplePulse  = 1'b1;
      dIn          = s[k];
      rateSelector = (k == 0) ? three : rsRest;
      if (k == n - 1) sb.push_back(e);
      @(posedge clk); #1;
      samplePulse  = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  // Recessive bits from the given frame count up to the intermission entry
  task automatic frame_to_im(input bit three, input int startCnt);
    for (int i = startCnt + 1; i < 8; i++)
      send_bit(3'b101, three, three, mk(1'b1, ST_FR, i, 1'b0, 1'b0));
    send_bit(3'b101, three, three, mk(1'b1, ST_IM, 0, 1'b0, 1'b0));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({bitValid, bitValue, interframePeriod, intermission,
                    suspendPeriod, overloadReq, sofDetect, bitCount}), 0);
  endtask

  // Monitor: a voted bit pops one expectation; the following cycle must show
  // the resulting state, counter and pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (bitValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bitValid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("bitValue", int'(bitValue), int'(e.val));
          @(negedge clk);
          if (reset) continue;
          chk("bitValid_width", int'(bitValid), 0);
          chk("intermission", int'(intermission), int'(e.st == ST_IM));
          chk("suspendPeriod", int'(suspendPeriod), int'(e.st == ST_SU));
          chk("interframePeriod", int'(interframePeriod), int'(e.st == ST_ID));
          chk("bitCount", int'(bitCount), int'(e.cnt));
          chk("overloadReq", int'(overloadReq), int'(e.ovl));
          chk("sofDetect", int'(sofDetect), int'(e.sof));
        end
      end else begin
        chk("stray_pulse", int'({overloadReq, sofDetect}), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    reset = 1'b0;

    // Single-sample: 11 recessive bits reach idle, no pulses
    frame_to_im(1'b0, 0);
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 2, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_ID, 0, 1'b0, 1'b0));

    // Three-sample 1,0,1 votes recessive; dominant in idle starts a frame
    send_bit(3'b100, 1'b1, 1'b1, mk(1'b0, ST_FR, 0, 1'b0, 1'b1));
    frame_to_im(1'b1, 0);
    send_bit(3'b101, 1'b1, 1'b1, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b101, 1'b1, 1'b1, mk(1'b1, ST_IM, 2, 1'b0, 1'b0));
    send_bit(3'b101, 1'b1, 1'b1, mk(1'b1, ST_ID, 0, 1'b0, 1'b0));
    send_bit(3'b010, 1'b1, 1'b1, mk(1'b0, ST_FR, 0, 1'b0, 1'b1));
    for (int i = 1; i <= 4; i++)
      send_bit(3'b101, 1'b1, 1'b1, mk(1'b1, ST_FR, i, 1'b0, 1'b0));
    // samples 0,0,1 at bit 5: dominant, run restarts
    send_bit(3'b100, 1'b1, 1'b1, mk(1'b0, ST_FR, 0, 1'b0, 1'b0));
    frame_to_im(1'b1, 0);

    // Overload at intermission bit 2
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b000, 1'b0, 1'b0, mk(1'b0, ST_FR, 0, 1'b1, 1'b0));
    // Dominant at intermission bit 3 is a start of frame
    frame_to_im(1'b0, 0);
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 2, 1'b0, 1'b0));
    send_bit(3'b000, 1'b0, 1'b0, mk(1'b0, ST_FR, 0, 1'b0, 1'b1));

    // Error-passive: 8 suspend bits then idle
    frame_to_im(1'b0, 0);
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 2, 1'b0, 1'b0));
    errorPassive = 1'b1;
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_SU, 0, 1'b0, 1'b0));
    for (int i = 1; i <= 7; i++)
      send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_SU, i, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_ID, 0, 1'b0, 1'b0));
    // Dominant at suspend bit 4
    send_bit(3'b000, 1'b0, 1'b0, mk(1'b0, ST_FR, 0, 1'b0, 1'b1));
    frame_to_im(1'b0, 0);
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_IM, 2, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_SU, 0, 1'b0, 1'b0));
    errorPassive = 1'b0;
    for (int i = 1; i <= 3; i++)
      send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_SU, i, 1'b0, 1'b0));
    send_bit(3'b000, 1'b0, 1'b0, mk(1'b0, ST_FR, 0, 1'b0, 1'b1));

    // Reset between 2nd and 3rd sample while in intermission
    frame_to_im(1'b0, 0);
    send_bit(3'b101, 1'b1, 1'b1, mk(1'b1, ST_IM, 1, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      samplePulse  = 1'b1;
      dIn          = 1'b0;
      rateSelector = 1'b1;
      @(posedge clk); #1;
      samplePulse  = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    // Fresh vote 1,1,0 -> recessive, counting from zero in S_FRAME
    send_bit(3'b011, 1'b1, 1'b1, mk(1'b1, ST_FR, 1, 1'b0, 1'b0));

    // Rate change mid-bit: still three pulses, then single-sample
    send_bit(3'b111, 1'b1, 1'b0, mk(1'b1, ST_FR, 2, 1'b0, 1'b0));
    send_bit(3'b111, 1'b0, 1'b0, mk(1'b1, ST_FR, 3, 1'b0, 1'b0));
    send_bit(3'b000, 1'b0, 1'b0, mk(1'b0, ST_FR, 0, 1'b0, 1'b0));

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
